// File: rtl/spu_iq_fetch_buffer_if.sv
// Fill-side and issue-side bundle for spu_iq_fetch_buffer.
// master = the queue, slave = the local-store/decode environment.
interface spu_iq_fetch_buffer_if #(
    parameter int INS_WD   = 32,
    parameter int LINE_INS = 32,
    parameter int DEPTH    = 64,
    parameter int ISSUE_WD = 2,
    parameter int PC_WD    = 32
);
    logic                              fill_req;
    logic [PC_WD-1:0]                  fill_addr;
    logic                              fill_ack;
    logic                              line_valid;
    logic [LINE_INS*INS_WD-1:0]        line_data;
    logic                              line_ready;
    logic                              flush;
    logic [PC_WD-1:0]                  flush_pc;
    logic [ISSUE_WD-1:0]               iss_valid;
    logic [ISSUE_WD*INS_WD-1:0]        iss_ins;
    logic [ISSUE_WD*PC_WD-1:0]         iss_pc;
    logic [$clog2(ISSUE_WD+1)-1:0]     iss_take;
    logic [$clog2(DEPTH+1)-1:0]        count;

    modport master (
        output fill_req, fill_addr, line_ready, iss_valid, iss_ins, iss_pc, count,
        input  fill_ack, line_valid, line_data, flush, flush_pc, iss_take
    );

    modport slave (
        input  fill_req, fill_addr, line_ready, iss_valid, iss_ins, iss_pc, count,
        output fill_ack, line_valid, line_data, flush, flush_pc, iss_take
    );
endinterface

// File: rtl/spu_iq_fetch_buffer.sv
// SPU instruction queue: fetches aligned local-store lines into a circular buffer and issues
// up to ISSUE_WD in-order instructions per cycle. Define SPU_IQ_STATS_EN for flush/empty counters.
module spu_iq_fetch_buffer #(
    parameter int               INS_WD   = 32,
    parameter int               LINE_INS = 32,
    parameter int               DEPTH    = 64,
    parameter int               ISSUE_WD = 2,
    parameter int               PC_WD    = 32,
    parameter logic [PC_WD-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst,
    spu_iq_fetch_buffer_if.master bus
`ifdef SPU_IQ_STATS_EN
    ,
    output logic [31:0] stat_flush,
    output logic [31:0] stat_empty
`endif
);

    localparam int LINE_BITS = $clog2(LINE_INS);
    localparam int PTR_WD    = $clog2(DEPTH);
    localparam int CNT_WD    = $clog2(DEPTH+1);
    localparam int TAKE_WD   = $clog2(ISSUE_WD+1);

    localparam logic [PC_WD-1:0] LINE_MASK  = PC_WD'(LINE_INS*4 - 1);
    localparam logic [PC_WD-1:0] LINE_BYTES = PC_WD'(LINE_INS*4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]           state;
    logic                 drop;
    logic [PC_WD-1:0]     req_addr;
    logic [PC_WD-1:0]     fetch_addr;
    logic [PC_WD-1:0]     head_pc;
    logic [LINE_BITS-1:0] skip;
    logic [PTR_WD-1:0]    head;
    logic [PTR_WD-1:0]    tail;
    logic [CNT_WD-1:0]    cnt;
    logic [INS_WD-1:0]    mem [DEPTH];

    logic [TAKE_WD-1:0]   avail;
    logic [TAKE_WD-1:0]   take_eff;
    logic                 line_fire;
    logic                 line_keep;
    logic [CNT_WD-1:0]    wr_n;
    logic [CNT_WD-1:0]    free_n;

    // A line arriving in the flush cycle or while a drop is pending is consumed but never written.
    always_comb begin
        avail     = (cnt >= CNT_WD'(ISSUE_WD)) ? TAKE_WD'(ISSUE_WD) : TAKE_WD'(cnt);
        take_eff  = (bus.iss_take > avail) ? avail : bus.iss_take;
        line_fire = (state == S_WAIT) && bus.line_valid;
        line_keep = line_fire && !drop && !bus.flush;
        wr_n      = CNT_WD'(LINE_INS) - CNT_WD'(skip);
        free_n    = CNT_WD'(DEPTH) - cnt;
    end

    // Space is reserved when leaving IDLE, so the line in flight always fits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            drop     <= 1'b0;
            req_addr <= RESET_PC & ~LINE_MASK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.flush && free_n >= CNT_WD'(LINE_INS)) begin
                        state    <= S_REQ;
                        req_addr <= fetch_addr;
                    end
                end
                S_REQ: begin
                    if (bus.flush) drop <= 1'b1;
                    if (bus.fill_ack) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (line_fire) begin
                        state <= S_IDLE;
                        drop  <= 1'b0;
                    end else if (bus.flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Flush overrides take and line write; the head lands on the redirect word at entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            head_pc    <= RESET_PC;
            fetch_addr <= RESET_PC & ~LINE_MASK;
            skip       <= RESET_PC[LINE_BITS+1:2];
        end else if (bus.flush) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            head_pc    <= bus.flush_pc;
            fetch_addr <= bus.flush_pc & ~LINE_MASK;
            skip       <= bus.flush_pc[LINE_BITS+1:2];
        end else begin
            head    <= head + PTR_WD'(take_eff);
            head_pc <= head_pc + (PC_WD'(take_eff) << 2);
            if (line_keep) begin
                tail       <= tail + PTR_WD'(wr_n);
                fetch_addr <= fetch_addr + LINE_BYTES;
                skip       <= '0;
                cnt        <= cnt + wr_n - CNT_WD'(take_eff);
            end else begin
                cnt <= cnt - CNT_WD'(take_eff);
            end
        end
    end

    // Words before the redirect offset are skipped so the tail stays packed.
    always_ff @(posedge clk) begin
        if (line_keep) begin
            for (int j = 0; j < LINE_INS; j++) begin
                if (j >= int'(skip)) begin
                    mem[tail + PTR_WD'(j) - PTR_WD'(skip)] <= bus.line_data[(LINE_INS-1-j)*INS_WD +: INS_WD];
                end
            end
        end
    end

    always_comb begin
        bus.iss_valid = '0;
        bus.iss_ins   = '0;
        bus.iss_pc    = '0;
        for (int i = 0; i < ISSUE_WD; i++) begin
            bus.iss_valid[i] = (cnt > CNT_WD'(i));
            bus.iss_ins[(ISSUE_WD-1-i)*INS_WD +: INS_WD] =
                (cnt > CNT_WD'(i)) ? mem[head + PTR_WD'(i)] : '0;
            bus.iss_pc[(ISSUE_WD-1-i)*PC_WD +: PC_WD] = head_pc + PC_WD'(4*i);
        end
    end

    assign bus.fill_req   = (state == S_REQ);
    assign bus.fill_addr  = req_addr;
    assign bus.line_ready = (state == S_WAIT);
    assign bus.count      = cnt;

`ifdef SPU_IQ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_flush <= '0;
            stat_empty <= '0;
        end else begin
            if (bus.flush && stat_flush != 32'hFFFF_FFFF) stat_flush <= stat_flush + 32'd1;
            if (cnt == '0 && stat_empty != 32'hFFFF_FFFF) stat_empty <= stat_empty + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spu_iq_fetch_buffer.sv
// Directed bench for spu_iq_fetch_buffer with a scoreboard of expected issue entries.
module tb_spu_iq_fetch_buffer;

    localparam int INS_WD   = 32;
    localparam int LINE_INS = 32;
    localparam int DEPTH    = 64;
    localparam int ISSUE_WD = 2;
    localparam int PC_WD    = 32;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic rst;
    ent_t sbq[$];
    int vectors;
    int miscompares;
    logic [31:0] line_addr;
    logic [31:0] data_base;
    int line_skip;

    spu_iq_fetch_buffer_if #(
        .INS_WD(INS_WD), .LINE_INS(LINE_INS), .DEPTH(DEPTH), .ISSUE_WD(ISSUE_WD), .PC_WD(PC_WD)
    ) bus ();

`ifdef SPU_IQ_STATS_EN
    logic [31:0] stat_flush;
    logic [31:0] stat_empty;
`endif

    spu_iq_fetch_buffer #(
        .INS_WD(INS_WD), .LINE_INS(LINE_INS), .DEPTH(DEPTH), .ISSUE_WD(ISSUE_WD),
        .PC_WD(PC_WD), .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SPU_IQ_STATS_EN
        ,
        .stat_flush(stat_flush),
        .stat_empty(stat_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [LINE_INS*INS_WD-1:0] make_line(input logic [31:0] base);
        logic [LINE_INS*INS_WD-1:0] l;
        for (int j = 0; j < LINE_INS; j++) l[(LINE_INS-1-j)*INS_WD +: INS_WD] = base + 32'(j);
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Count, valid mask and every visible lane against the scoreboard head.
    task automatic checkIssue(input string tag);
        int n;
        int v;
        n = sbq.size();
        v = (n > ISSUE_WD) ? ISSUE_WD : n;
        checkOutput({tag, "_count"}, 64'(bus.count), 64'(n));
        checkOutput({tag, "_valid"}, 64'(bus.iss_valid), (v == 2) ? 64'd3 : 64'(v));
        for (int i = 0; i < v; i++) begin
            checkOutput($sformatf("%s_ins%0d", tag, i), 64'(bus.iss_ins[(ISSUE_WD-1-i)*INS_WD +: INS_WD]), 64'(sbq[i].ins));
            checkOutput($sformatf("%s_pc%0d", tag, i), 64'(bus.iss_pc[(ISSUE_WD-1-i)*PC_WD +: PC_WD]), 64'(sbq[i].pc));
        end
    endtask

    // One clock: drive inputs, take the edge, update the scoreboard, release pulses.
    task automatic applyStimulus(input int take, input bit ack, input bit lv, input bit keep,
                                 input bit fl, input logic [31:0] fpc);
        bus.iss_take   = 2'(take);
        bus.fill_ack   = ack;
        bus.line_valid = lv;
        bus.line_data  = make_line(data_base);
        bus.flush      = fl;
        bus.flush_pc   = fpc;
        @(posedge clk);
        if (fl) begin
            sbq.delete();
        end else begin
            for (int k = 0; k < take; k++) if (sbq.size() > 0) void'(sbq.pop_front());
            if (lv && keep) begin
                for (int j = line_skip; j < LINE_INS; j++)
                    sbq.push_back('{ins: data_base + 32'(j), pc: line_addr + 32'(4*j)});
            end
        end
        #1;
        bus.iss_take   = '0;
        bus.fill_ack   = 1'b0;
        bus.line_valid = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic waitReq(input int take, input string tag);
        for (int c = 0; c < 40 && bus.fill_req !== 1'b1; c++) applyStimulus(take, 0, 0, 0, 0, 32'h0);
        checkOutput(tag, 64'(bus.fill_req), 64'd1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        line_addr = '0;
        data_base = '0;
        line_skip = 0;
        bus.fill_ack = 1'b0;
        bus.line_valid = 1'b0;
        bus.line_data = '0;
        bus.flush = 1'b0;
        bus.flush_pc = '0;
        bus.iss_take = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_fill_req", 64'(bus.fill_req), 64'd0);
        checkOutput("rst_line_ready", 64'(bus.line_ready), 64'd0);
        checkOutput("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        checkOutput("rst_count", 64'(bus.count), 64'd0);
        checkOutput("rst_fill_addr", 64'(bus.fill_addr), 64'd0);
        checkOutput("rst_iss_ins", 64'(bus.iss_ins), 64'd0);
        checkOutput("rst_iss_pc0", 64'(bus.iss_pc[63:32]), 64'd0);
        rst = 1'b1;

        // Cold start
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("cold_req", 64'(bus.fill_req), 64'd1);
        checkOutput("cold_addr", 64'(bus.fill_addr), 64'd0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        checkOutput("cold_ready", 64'(bus.line_ready), 64'd1);
        checkOutput("cold_req_low", 64'(bus.fill_req), 64'd0);
        line_addr = 32'h0; data_base = 32'h100; line_skip = 0;
        applyStimulus(0, 0, 1, 1, 0, 32'h0);
        checkIssue("cold");
        checkOutput("cold_ins0", 64'(bus.iss_ins[63:32]), 64'h100);
        checkOutput("cold_ins1", 64'(bus.iss_ins[31:0]), 64'h101);
        checkOutput("cold_pc1", 64'(bus.iss_pc[31:0]), 64'h4);

        // Drain with the refill request parked, including a clamped take at count 1
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        checkOutput("drain_req", 64'(bus.fill_req), 64'd1);
        checkOutput("drain_addr0", 64'(bus.fill_addr), 64'h80);
        checkIssue("drain_first");
        for (int c = 0; c < 15; c++) begin
            applyStimulus(2, 0, 0, 0, 0, 32'h0);
            checkIssue("drain");
            checkOutput("drain_addr", 64'(bus.fill_addr), 64'h80);
        end
        checkOutput("drain_cnt1", 64'(bus.count), 64'd1);
        applyStimulus(2, 0, 0, 0, 0, 32'h0);
        checkOutput("clamp_cnt", 64'(bus.count), 64'd0);
        applyStimulus(2, 0, 0, 0, 0, 32'h0);
        checkIssue("underflow");
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        checkOutput("refill_ready", 64'(bus.line_ready), 64'd1);
        line_addr = 32'h80; data_base = 32'h200;
        applyStimulus(0, 0, 1, 1, 0, 32'h0);
        checkIssue("refill");

        // Write and take in the same cycle
        applyStimulus(2, 0, 0, 0, 0, 32'h0);
        checkOutput("wt_addr", 64'(bus.fill_addr), 64'h100);
        applyStimulus(2, 1, 0, 0, 0, 32'h0);
        repeat (9) applyStimulus(2, 0, 0, 0, 0, 32'h0);
        checkOutput("wt_pre_cnt", 64'(bus.count), 64'd10);
        line_addr = 32'h100; data_base = 32'h300;
        applyStimulus(2, 0, 1, 1, 0, 32'h0);
        checkOutput("wt_cnt", 64'(bus.count), 64'd40);
        checkIssue("wt");

        // Flush colliding with a line and a take
        waitReq(2, "fl_req_seen");
        checkOutput("fl_addr", 64'(bus.fill_addr), 64'h180);
        checkIssue("fl_pre");
        applyStimulus(2, 1, 0, 0, 0, 32'h0);
        line_addr = 32'h180; data_base = 32'h400;
        applyStimulus(2, 0, 1, 0, 1, 32'h400);
        checkIssue("fl_line");
        checkOutput("fl_ready", 64'(bus.line_ready), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("fl_newaddr", 64'(bus.fill_addr), 64'h400);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);

        // Misaligned redirect while waiting for a line
        applyStimulus(0, 0, 0, 0, 1, 32'h1C8);
        checkIssue("mis_flush");
        checkOutput("mis_ready", 64'(bus.line_ready), 64'd1);
        line_addr = 32'h400; data_base = 32'h500;
        applyStimulus(0, 0, 1, 0, 0, 32'h0);
        checkIssue("mis_drop");
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("mis_addr", 64'(bus.fill_addr), 64'h180);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        line_addr = 32'h180; data_base = 32'h600; line_skip = 18;
        applyStimulus(0, 0, 1, 1, 0, 32'h0);
        line_skip = 0;
        checkOutput("mis_cnt", 64'(bus.count), 64'd14);
        checkOutput("mis_pc0", 64'(bus.iss_pc[63:32]), 64'h1C8);
        checkOutput("mis_ins0", 64'(bus.iss_ins[63:32]), 64'h612);
        checkIssue("mis");

        // Flush during REQ
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("rq_addr", 64'(bus.fill_addr), 64'h200);
        applyStimulus(0, 0, 0, 0, 1, 32'h800);
        checkOutput("rq_hold_req", 64'(bus.fill_req), 64'd1);
        checkOutput("rq_hold_addr", 64'(bus.fill_addr), 64'h200);
        checkOutput("rq_cnt", 64'(bus.count), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("rq_hold_addr2", 64'(bus.fill_addr), 64'h200);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        checkOutput("rq_ready", 64'(bus.line_ready), 64'd1);
        line_addr = 32'h200; data_base = 32'h700;
        applyStimulus(0, 0, 1, 0, 0, 32'h0);
        checkIssue("rq_drop");
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("rq_newaddr", 64'(bus.fill_addr), 64'h800);
`ifdef SPU_IQ_STATS_EN
        checkOutput("stat_flush", 64'(stat_flush), 64'd3);
`endif

        // Asynchronous reset while waiting for a line
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        line_addr = 32'h800; data_base = 32'h900;
        applyStimulus(0, 0, 1, 1, 0, 32'h0);
        checkIssue("pre_rst");
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("pre_rst_addr", 64'(bus.fill_addr), 64'h880);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        checkOutput("pre_rst_ready", 64'(bus.line_ready), 64'd1);
        checkOutput("pre_rst_valid", 64'(bus.iss_valid), 64'd3);
        #2 rst = 1'b0;
        #1;
        sbq.delete();
        checkOutput("arst_fill_req", 64'(bus.fill_req), 64'd0);
        checkOutput("arst_ready", 64'(bus.line_ready), 64'd0);
        checkOutput("arst_valid", 64'(bus.iss_valid), 64'd0);
        checkOutput("arst_count", 64'(bus.count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("post_rst_req", 64'(bus.fill_req), 64'd1);
        checkOutput("post_rst_addr", 64'(bus.fill_addr), 64'h0);
        checkIssue("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
